// File: rtl/antirebote_pkg.sv
// Shared types and width helper for the multi-channel debouncer.
package antirebote_pkg;

   typedef enum logic [1:0] {
      BAJO = 2'b00,
      SUBE = 2'b01,
      ALTO = 2'b10,
      BAJA = 2'b11
   } estado_t;

   // Bits needed to hold 0..max_val, never less than one.
   function automatic int unsigned cnt_w(input int unsigned max_val);
      return (max_val == 0) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/antirebote_canal.sv
// One debounce channel: synchroniser, stability FSM, edge pulses and long-press detector.
module antirebote_canal #(
   parameter int unsigned STABLE = 4,
   parameter int unsigned HOLD   = 16,
   parameter int unsigned SYNC   = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic din,
   output logic dout,
   output logic rise,
   output logic fall,
   output logic hold
);
   import antirebote_pkg::*;

   localparam int unsigned     CW        = cnt_w(STABLE);
   localparam int unsigned     HW        = cnt_w(HOLD);
   localparam logic [CW-1:0]   CNT_LAST  = CW'(STABLE);
   localparam bit              HOLD_EN   = (HOLD != 0);
   localparam logic [HW-1:0]   HOLD_MAX  = HW'(HOLD);
   localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD_EN ? HOLD - 1 : 0);

   logic [SYNC-1:0] sync_q, sync_d;
   estado_t         state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
   logic [HW-1:0]   hcnt_q, hcnt_d;
   logic            dout_q, dout_d;
   logic            rise_q, rise_d;
   logic            fall_q, fall_d;
   logic            hold_q, hold_d;
   logic            s;

   // Synchroniser runs every cycle regardless of en.
   always_comb begin
      sync_d = {sync_q[SYNC-2:0], din};
   end

   assign s = sync_q[SYNC-1];

   // Stability FSM: a level must persist STABLE enabled cycles before dout follows it.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dout_d  = dout_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      cnt_inc = cnt_q + CW'(1);
      if (en) begin
         case (state_q)
            BAJO: begin
               if (s) begin
                  if (STABLE == 1) begin
                     state_d = ALTO;
                     dout_d  = 1'b1;
                     rise_d  = 1'b1;
                     cnt_d   = '0;
                  end else begin
                     state_d = SUBE;
                     cnt_d   = CW'(1);
                  end
               end
            end
            SUBE: begin
               if (!s) begin
                  state_d = BAJO;
                  cnt_d   = '0;
               end else if (cnt_inc == CNT_LAST) begin
                  state_d = ALTO;
                  dout_d  = 1'b1;
                  rise_d  = 1'b1;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            ALTO: begin
               if (!s) begin
                  if (STABLE == 1) begin
                     state_d = BAJO;
                     dout_d  = 1'b0;
                     fall_d  = 1'b1;
                     cnt_d   = '0;
                  end else begin
                     state_d = BAJA;
                     cnt_d   = CW'(1);
                  end
               end
            end
            BAJA: begin
               if (s) begin
                  state_d = ALTO;
                  cnt_d   = '0;
               end else if (cnt_inc == CNT_LAST) begin
                  state_d = BAJO;
                  dout_d  = 1'b0;
                  fall_d  = 1'b1;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            default: begin
               state_d = BAJO;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Long-press counter saturates at HOLD; a fall on the same edge suppresses the pulse.
   always_comb begin
      hcnt_d = hcnt_q;
      hold_d = 1'b0;
      if (rise_d || fall_d) begin
         hcnt_d = '0;
      end else if (HOLD_EN && en && (state_q == ALTO || state_q == BAJA) &&
                   (hcnt_q != HOLD_MAX)) begin
         hcnt_d = hcnt_q + HW'(1);
         hold_d = (hcnt_q == HOLD_LAST);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= '0;
         state_q <= BAJO;
         cnt_q   <= '0;
         hcnt_q  <= '0;
         dout_q  <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
         hold_q  <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hcnt_q  <= hcnt_d;
         dout_q  <= dout_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         hold_q  <= hold_d;
      end
   end

   assign dout = dout_q;
   assign rise = rise_q;
   assign fall = fall_q;
   assign hold = hold_q;

endmodule

// File: rtl/antirebote_n.sv
// N independent debounce channels sharing clock, reset and count enable.
module antirebote_n #(
   parameter int unsigned N      = 5,
   parameter int unsigned STABLE = 4,
   parameter int unsigned HOLD   = 16,
   parameter int unsigned SYNC   = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic [N-1:0] din,
   output logic [N-1:0] dout,
   output logic [N-1:0] rise,
   output logic [N-1:0] fall,
   output logic [N-1:0] hold
);

   for (genvar i = 0; i < N; i++) begin : g_canal
      antirebote_canal #(
         .STABLE (STABLE),
         .HOLD   (HOLD),
         .SYNC   (SYNC)
      ) u_canal (
         .clk   (clk),
         .rst_n (reset),
         .en    (en),
         .din   (din[i]),
         .dout  (dout[i]),
         .rise  (rise[i]),
         .fall  (fall[i]),
         .hold  (hold[i])
      );
   end

endmodule

// File: tb/tb_antirebote_n.sv
// Directed bench for antirebote_n: default instance plus a STABLE=1/HOLD=0 instance.
module tb_antirebote_n;

   localparam int unsigned N = 5;

   logic         clk = 1'b0;
   logic         reset;
   logic         en;
   logic [N-1:0] din, dout, rise, fall, hold;
   logic [N-1:0] din1, dout1, rise1, fall1, hold1;

   int unsigned n_vec = 0;
   int unsigned n_bad = 0;

   always #5 clk = ~clk;

   antirebote_n u_dut (
      .clk   (clk),
      .reset (reset),
      .en    (en),
      .din   (din),
      .dout  (dout),
      .rise  (rise),
      .fall  (fall),
      .hold  (hold)
   );

   antirebote_n #(.STABLE(1), .HOLD(0)) u_dut1 (
      .clk   (clk),
      .reset (reset),
      .en    (en),
      .din   (din1),
      .dout  (dout1),
      .rise  (rise1),
      .fall  (fall1),
      .hold  (hold1)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      en    = 1'b1;
      din   = '0;
      din1  = '0;
      #2;
      reset = 1'b0;
      din   = 5'h1f;
      #1;
      chk("rst_async_dout", dout, 5'h00);

      // Reset held with all inputs high
      repeat (3) begin
         tick();
         chk("rst_dout", dout, 5'h00);
         chk("rst_rise", rise, 5'h00);
         chk("rst_fall", fall, 5'h00);
         chk("rst_hold", hold, 5'h00);
      end
      reset = 1'b1;
      for (int i = 1; i <= 7; i++) begin
         tick();
         chk("rel_dout", dout, (i >= 6) ? 5'h1f : 5'h00);
         chk("rel_rise", rise, (i == 6) ? 5'h1f : 5'h00);
      end
      din = '0;
      for (int i = 1; i <= 7; i++) begin
         tick();
         chk("all_dout", dout, (i >= 6) ? 5'h00 : 5'h1f);
         chk("all_fall", fall, (i == 6) ? 5'h1f : 5'h00);
      end

      // Glitch of 3 cycles on channel 1 is discarded
      for (int i = 1; i <= 11; i++) begin
         din[1] = (i <= 3);
         tick();
         chk("glitch_dout", dout, 5'h00);
         chk("glitch_rise", rise, 5'h00);
      end
      din[1] = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         tick();
         chk("pulse_dout", dout, (i >= 6) ? 5'h02 : 5'h00);
         chk("pulse_rise", rise, (i == 6) ? 5'h02 : 5'h00);
      end
      din[1] = 1'b0;
      repeat (10) tick();
      chk("pulse_end_dout", dout, 5'h00);

      // Long press on channel 2
      din[2] = 1'b1;
      for (int i = 1; i <= 40; i++) begin
         tick();
         chk("long_dout", dout, (i >= 6) ? 5'h04 : 5'h00);
         chk("long_rise", rise, (i == 6) ? 5'h04 : 5'h00);
         chk("long_hold", hold, (i == 22) ? 5'h04 : 5'h00);
      end
      din[2] = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         tick();
         chk("long_rel_dout", dout, (i >= 6) ? 5'h00 : 5'h04);
         chk("long_rel_fall", fall, (i == 6) ? 5'h04 : 5'h00);
         chk("long_rel_hold", hold, 5'h00);
      end

      // Enable gating on channel 0
      din[0] = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         en = (i % 2 == 1);
         tick();
         chk("gate_dout", dout, (i >= 9) ? 5'h01 : 5'h00);
         chk("gate_rise", rise, (i == 9) ? 5'h01 : 5'h00);
      end
      en     = 1'b1;
      din[0] = 1'b0;
      repeat (10) tick();
      chk("gate_end_dout", dout, 5'h00);

      // Reset in the middle of channel 3 counting, with channel 4 already high
      din[4] = 1'b1;
      repeat (6) tick();
      chk("mid_pre4_dout", dout, 5'h10);
      din[3] = 1'b1;
      repeat (4) tick();
      chk("mid_pre_dout", dout, 5'h10);
      #2;
      reset = 1'b0;
      #1;
      chk("mid_async_dout", dout, 5'h00);
      tick();
      chk("mid_rst_dout", dout, 5'h00);
      chk("mid_rst_rise", rise, 5'h00);
      reset = 1'b1;
      for (int i = 1; i <= 7; i++) begin
         tick();
         chk("mid_rel_dout", dout, (i >= 6) ? 5'h18 : 5'h00);
         chk("mid_rel_rise", rise, (i == 6) ? 5'h18 : 5'h00);
      end

      // Channel 0 rises while channel 4 falls; channel 3 keeps its long-press timing
      din = 5'h09;
      for (int i = 1; i <= 16; i++) begin
         tick();
         chk("ind_dout", dout, (i >= 6) ? 5'h09 : 5'h18);
         chk("ind_rise", rise, (i == 6) ? 5'h01 : 5'h00);
         chk("ind_fall", fall, (i == 6) ? 5'h10 : 5'h00);
         chk("ind_hold", hold, (i == 15) ? 5'h08 : 5'h00);
      end
      din = '0;
      repeat (10) tick();
      chk("ind_end_dout", dout, 5'h00);

      // STABLE=1, HOLD=0 instance
      din1 = 5'h10;
      for (int i = 1; i <= 4; i++) begin
         tick();
         chk("s1_dout", dout1, (i >= 3) ? 5'h10 : 5'h00);
         chk("s1_rise", rise1, (i == 3) ? 5'h10 : 5'h00);
      end
      din1 = 5'h01;
      for (int i = 1; i <= 20; i++) begin
         tick();
         chk("s1_ind_dout", dout1, (i >= 3) ? 5'h01 : 5'h10);
         chk("s1_ind_rise", rise1, (i == 3) ? 5'h01 : 5'h00);
         chk("s1_ind_fall", fall1, (i == 3) ? 5'h10 : 5'h00);
         chk("s1_hold", hold1, 5'h00);
      end
      din1 = '0;
      for (int i = 1; i <= 4; i++) begin
         tick();
         chk("s1_rel_dout", dout1, (i >= 3) ? 5'h00 : 5'h01);
         chk("s1_rel_fall", fall1, (i == 3) ? 5'h01 : 5'h00);
         chk("s1_rel_other", dout, 5'h00);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
